// File: rtl/rom_dl.sv
// Downloadable read-only memory: a LOAD phase fills it word by word,
// then IDLE serves pipelined reads with a 1- or 2-cycle latency.
module rom_dl #(
    parameter int KB  = 16,
    parameter int DW  = 8,
    parameter int LAT = 1,
    parameter     FN  = ""
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [$clog2(KB*1024)-1:0]  a,
    input  logic                        rd,
    output logic [DW-1:0]               q,
    output logic                        qv,
    input  logic                        dl_start,
    input  logic                        dl_we,
    input  logic [DW-1:0]               dl_d,
    input  logic                        dl_end,
    output logic                        busy,
    output logic                        loaded,
    output logic                        ovf,
    output logic [$clog2(KB*1024):0]    count
);

    localparam int DEPTH  = KB * 1024;
    localparam int AW     = $clog2(DEPTH);
    localparam bit HAS_FN = (FN != "");

    typedef enum logic {IDLE, LOAD} state_t;

    logic            sync0_q, sync1_q, en;
    state_t          state_q, state_d;
    logic [AW:0]     ptr_q, ptr_d;
    logic            ovf_q, ovf_d;
    logic            loaded_q, loaded_d;
    logic            we;
    logic            req, acc;
    logic            fin_req, fin_ok;
    logic [DW-1:0]   fin_dat;
    logic [DW-1:0]   q_q, q_d;
    logic            qv_q, qv_d;

    logic [DW-1:0]   mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= 1'b1;
            sync1_q <= sync0_q;
        end
    end

    assign en = sync1_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        ovf_d    = ovf_q;
        loaded_d = loaded_q;
        we       = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (dl_start) begin
                        state_d  = LOAD;
                        ptr_d    = '0;
                        ovf_d    = 1'b0;
                        loaded_d = 1'b0;
                    end
                end
                LOAD: begin
                    if (dl_start) begin
                        ptr_d = '0;
                        ovf_d = 1'b0;
                    end else begin
                        if (dl_we) begin
                            if (ptr_q == (AW+1)'(DEPTH)) begin
                                ovf_d = 1'b1;
                            end else begin
                                we    = 1'b1;
                                ptr_d = ptr_q + 1'b1;
                            end
                        end
                        if (dl_end) begin
                            state_d  = IDLE;
                            loaded_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            loaded_q <= HAS_FN;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            loaded_q <= loaded_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) mem[ptr_q[AW-1:0]] <= dl_d;
    end

    assign req = en & rd;
    assign acc = req & (state_q == IDLE) & loaded_q;

    generate
        if (LAT == 2) begin : g_lat2
            logic          s_req_q, s_ok_q;
            logic [DW-1:0] s_dat_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s_req_q <= 1'b0;
                    s_ok_q  <= 1'b0;
                end else begin
                    s_req_q <= req;
                    s_ok_q  <= acc;
                end
            end

            always_ff @(posedge clock) begin
                s_dat_q <= mem[a];
            end

            assign fin_req = s_req_q;
            assign fin_ok  = s_ok_q;
            assign fin_dat = s_dat_q;
        end else begin : g_lat1
            assign fin_req = req;
            assign fin_ok  = acc;
            assign fin_dat = mem[a];
        end
    endgenerate

    always_comb begin
        q_d  = q_q;
        qv_d = fin_req & fin_ok;
        if (fin_req) q_d = fin_ok ? fin_dat : '1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q  <= '0;
            qv_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            qv_q <= qv_d;
        end
    end

    assign q      = q_q;
    assign qv     = qv_q;
    assign busy   = (state_q == LOAD);
    assign loaded = loaded_q;
    assign ovf    = ovf_q;
    assign count  = ptr_q;

endmodule

// File: tb/tb_rom_dl.sv
// Directed bench for rom_dl: a LAT=1 and a LAT=2 instance (KB=1)
// driven by the same stimulus, checked with immediate assertions.
module tb_rom_dl;

    logic        clock;
    logic        reset;
    logic [9:0]  a;
    logic        rd;
    logic        dl_start, dl_we, dl_end;
    logic [7:0]  dl_d;

    logic [7:0]  q0, q1;
    logic        qv0, qv1;
    logic        busy0, busy1;
    logic        loaded0, loaded1;
    logic        ovf0, ovf1;
    logic [10:0] count0, count1;

    int n_chk;
    int n_fail;

    rom_dl #(.KB(1), .DW(8), .LAT(1), .FN("")) u0 (
        .clock(clock), .reset(reset), .a(a), .rd(rd),
        .q(q0), .qv(qv0),
        .dl_start(dl_start), .dl_we(dl_we), .dl_d(dl_d), .dl_end(dl_end),
        .busy(busy0), .loaded(loaded0), .ovf(ovf0), .count(count0)
    );

    rom_dl #(.KB(1), .DW(8), .LAT(2), .FN("")) u1 (
        .clock(clock), .reset(reset), .a(a), .rd(rd),
        .q(q1), .qv(qv1),
        .dl_start(dl_start), .dl_we(dl_we), .dl_d(dl_d), .dl_end(dl_end),
        .busy(busy1), .loaded(loaded1), .ovf(ovf1), .count(count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b0;
        a        = '0;
        rd       = 1'b0;
        dl_start = 1'b0;
        dl_we    = 1'b0;
        dl_end   = 1'b0;
        dl_d     = '0;

        step();
        step();
        chk("rst_q", 32'(q0), 32'h0);
        chk("rst_qv", 32'(qv0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_count", 32'(count0), 32'h0);
        chk("rst_ovf", 32'(ovf0), 32'h0);
        chk("rst_loaded", 32'(loaded0), 32'h0);

        // dl_start during the first two edges after release is ignored
        reset    = 1'b1;
        dl_start = 1'b1;
        step();
        step();
        dl_start = 1'b0;
        chk("sync_ignore", 32'(busy0), 32'h0);

        // dl_start together with dl_end: start wins
        dl_start = 1'b1;
        dl_end   = 1'b1;
        step();
        dl_start = 1'b0;
        dl_end   = 1'b0;
        chk("start_end_busy", 32'(busy0), 32'h1);

        // three words, last one together with dl_end
        dl_we = 1'b1;
        dl_d  = 8'h11;
        step();
        dl_d  = 8'h22;
        step();
        dl_d   = 8'h33;
        dl_end = 1'b1;
        step();
        dl_we  = 1'b0;
        dl_end = 1'b0;
        chk("dl1_busy", 32'(busy0), 32'h0);
        chk("dl1_count", 32'(count0), 32'd3);
        chk("dl1_loaded", 32'(loaded0), 32'h1);
        chk("dl1_ovf", 32'(ovf0), 32'h0);

        rd = 1'b1;
        a  = 10'd1;
        step();
        chk("rd1_q", 32'(q0), 32'h22);
        chk("rd1_qv", 32'(qv0), 32'h1);
        rd = 1'b1;
        a  = 10'd2;
        step();
        rd = 1'b0;
        chk("rd_last_word_q", 32'(q0), 32'h33);
        step();
        chk("hold_qv", 32'(qv0), 32'h0);
        chk("hold_q", 32'(q0), 32'h33);

        // second download of four words for the pipelined read test
        dl_start = 1'b1;
        step();
        dl_start = 1'b0;
        dl_we    = 1'b1;
        dl_d     = 8'hA0;
        step();
        dl_d = 8'hA1;
        step();
        dl_d = 8'hA2;
        step();
        dl_d   = 8'hA3;
        dl_end = 1'b1;
        step();
        dl_we  = 1'b0;
        dl_end = 1'b0;
        chk("dl2_count", 32'(count0), 32'd4);

        // back-to-back reads a=0..3
        rd = 1'b1;
        a  = 10'd0;
        step();
        chk("p0_q0", 32'(q0), 32'hA0);
        chk("p0_qv1", 32'(qv1), 32'h0);
        a = 10'd1;
        step();
        chk("p1_q0", 32'(q0), 32'hA1);
        chk("p1_q1", 32'(q1), 32'hA0);
        chk("p1_qv1", 32'(qv1), 32'h1);
        a = 10'd2;
        step();
        chk("p2_q1", 32'(q1), 32'hA1);
        chk("p2_qv1", 32'(qv1), 32'h1);
        a = 10'd3;
        step();
        chk("p3_q1", 32'(q1), 32'hA2);
        chk("p3_qv1", 32'(qv1), 32'h1);
        rd = 1'b0;
        step();
        chk("p4_q1", 32'(q1), 32'hA3);
        chk("p4_qv1", 32'(qv1), 32'h1);
        step();
        chk("p5_qv1", 32'(qv1), 32'h0);

        // read one cycle before dl_start completes; reads in LOAD refused
        rd = 1'b1;
        a  = 10'd0;
        step();
        chk("pre_q0", 32'(q0), 32'hA0);
        rd       = 1'b0;
        dl_start = 1'b1;
        step();
        dl_start = 1'b0;
        chk("enter_busy", 32'(busy0), 32'h1);
        chk("inflight_q1", 32'(q1), 32'hA0);
        chk("inflight_qv1", 32'(qv1), 32'h1);
        rd = 1'b1;
        a  = 10'd2;
        step();
        rd = 1'b0;
        chk("load_rd_q0", 32'(q0), 32'hFF);
        chk("load_rd_qv0", 32'(qv0), 32'h0);
        step();
        chk("load_rd_q1", 32'(q1), 32'hFF);
        chk("load_rd_qv1", 32'(qv1), 32'h0);

        // five words, then reset in mid-download
        dl_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dl_d = 8'hB0 + 8'(i);
            step();
        end
        dl_we = 1'b0;
        chk("mid_count", 32'(count0), 32'd5);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_count", 32'(count0), 32'h0);
        chk("arst_loaded", 32'(loaded0), 32'h0);
        chk("arst_q", 32'(q0), 32'h0);
        reset = 1'b1;
        step();
        step();

        // new download of two words
        dl_start = 1'b1;
        step();
        dl_start = 1'b0;
        dl_we    = 1'b1;
        dl_d     = 8'hC0;
        step();
        dl_d   = 8'hC1;
        dl_end = 1'b1;
        step();
        dl_we  = 1'b0;
        dl_end = 1'b0;
        chk("dl3_count", 32'(count0), 32'd2);
        chk("dl3_loaded", 32'(loaded0), 32'h1);
        rd = 1'b1;
        a  = 10'd1;
        step();
        chk("dl3_rd1", 32'(q0), 32'hC1);
        a = 10'd4;
        step();
        rd = 1'b0;
        chk("keep_rd4", 32'(q0), 32'hB4);

        // overflow: 1025 words into a 1024-word memory
        dl_start = 1'b1;
        step();
        dl_start = 1'b0;
        dl_we    = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dl_d = 8'(i + 3);
            step();
        end
        chk("full_ovf", 32'(ovf0), 32'h0);
        dl_d = 8'hEE;
        step();
        dl_we = 1'b0;
        chk("ovf_count", 32'(count0), 32'd1024);
        chk("ovf_flag", 32'(ovf0), 32'h1);
        dl_end = 1'b1;
        step();
        dl_end = 1'b0;
        chk("ovf_loaded", 32'(loaded0), 32'h1);

        // dl_we outside LOAD is ignored
        dl_we = 1'b1;
        dl_d  = 8'h77;
        step();
        dl_we = 1'b0;
        chk("idle_we_count", 32'(count0), 32'd1024);
        chk("idle_we_ovf", 32'(ovf0), 32'h1);

        rd = 1'b1;
        a  = 10'd0;
        step();
        chk("ovf_mem0", 32'(q0), 32'h03);
        a = 10'd1023;
        step();
        rd = 1'b0;
        chk("ovf_mem1023", 32'(q0), 32'h02);
        step();
        chk("ovf_mem1023_q1", 32'(q1), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
